// File: rtl/ldpc_encode_ctrl.sv
// ldpc_encode_ctrl
// Sequencing controller for a systematic LDPC encode datapath.
// Holds the generator-P rows loaded over a config port, hands each
// accepted info word to the encoder for ENC_LAT cycles, captures the
// resulting codeword and presents it downstream until it is accepted.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both high. Once raised, o_valid stays high and
// o_codeword stays stable until the transfer. o_ready is high only in IDLE,
// so no input word is ever latched unless o_ready was 1 in that cycle.

module ldpc_encode_ctrl #(
  parameter int N       = 11,
  parameter int K       = 6,
  parameter int ENC_LAT = 1
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_cfg_we,
  input  logic [$clog2(K)-1:0]   i_cfg_addr,
  input  logic [N-K-1:0]         i_cfg_data,
  input  logic                   i_cfg_clr,
  input  logic                   i_valid,
  input  logic [K-1:0]           i_info,
  output logic                   o_ready,
  output logic                   o_enc_en,
  output logic [K-1:0]           o_info_bits,
  output logic [K*(N-K)-1:0]     o_generator_p,
  input  logic [N-1:0]           i_codeword,
  output logic                   o_valid,
  output logic [N-1:0]           o_codeword,
  input  logic                   i_ready,
  output logic                   o_cfg_ok,
  output logic                   o_sys_err,
  output logic [1:0]             dbg_state
);

  localparam int PW = N - K;
  localparam int AW = $clog2(K);
  localparam int LW = (ENC_LAT > 1) ? $clog2(ENC_LAT) : 1;
  localparam logic [AW:0]   K_ROWS   = (AW + 1)'(K);
  localparam logic [LW-1:0] LAT_LOAD = LW'(ENC_LAT - 1);

  typedef enum logic [1:0] {
    S_CFG  = 2'd0,
    S_IDLE = 2'd1,
    S_ENC  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t        state;
  logic [K-1:0]  mask;
  logic [K-1:0]  wr_hit;
  logic [K-1:0]  mask_next;
  logic [LW-1:0] lat_cnt;
  logic          cfg_open;
  logic          wr_ok;

  assign dbg_state = state;

  // Decode which row (if any) a config write targets this cycle.
  // Writes are only taken in CFG/IDLE, never alongside a clear, and never
  // for an address beyond the last row.
  always_comb begin
    cfg_open  = (state == S_CFG) || (state == S_IDLE);
    wr_ok     = i_cfg_we && cfg_open && !i_cfg_clr &&
                ({1'b0, i_cfg_addr} < K_ROWS);
    wr_hit    = '0;
    for (int r = 0; r < K; r++) begin
      wr_hit[r] = wr_ok && (i_cfg_addr == AW'(r));
    end
    mask_next = mask | wr_hit;
  end

  // Controller FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_CFG;
      mask          <= '0;
      lat_cnt       <= '0;
      o_ready       <= 1'b0;
      o_enc_en      <= 1'b0;
      o_valid       <= 1'b0;
      o_cfg_ok      <= 1'b0;
      o_sys_err     <= 1'b0;
      o_info_bits   <= '0;
      o_codeword    <= '0;
      o_generator_p <= '0;
    end else if (i_cfg_clr) begin
      // Clear drops any in-flight word; the error flag is kept sticky.
      state    <= S_CFG;
      mask     <= '0;
      o_ready  <= 1'b0;
      o_enc_en <= 1'b0;
      o_valid  <= 1'b0;
      o_cfg_ok <= 1'b0;
    end else begin
      mask     <= mask_next;
      o_cfg_ok <= &mask_next;
      for (int r = 0; r < K; r++) begin
        if (wr_hit[r]) begin
          o_generator_p[r*PW +: PW] <= i_cfg_data;
        end
      end
      case (state)
        S_CFG: begin
          // Leave CFG on the same edge that completes the row mask.
          if (&mask_next) begin
            state   <= S_IDLE;
            o_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (i_valid && o_ready) begin
            o_info_bits <= i_info;
            lat_cnt     <= LAT_LOAD;
            state       <= S_ENC;
            o_ready     <= 1'b0;
            o_enc_en    <= 1'b1;
          end
        end
        S_ENC: begin
          if (lat_cnt == '0) begin
            o_codeword <= i_codeword;
            // Systematic part of the codeword must equal the info word.
            if (i_codeword[N-1 -: K] != o_info_bits) begin
              o_sys_err <= 1'b1;
            end
            state    <= S_HOLD;
            o_enc_en <= 1'b0;
            o_valid  <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        S_HOLD: begin
          if (i_ready) begin
            state   <= S_IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state    <= S_CFG;
          o_ready  <= 1'b0;
          o_enc_en <= 1'b0;
          o_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_encode_ctrl.sv
// Directed bench for ldpc_encode_ctrl with a behavioural encoder model.
module tb_ldpc_encode_ctrl;

  localparam int N  = 11;
  localparam int K  = 6;
  localparam int PW = N - K;

  localparam logic [K*PW-1:0] GP_FULL    = 30'b010010101001100100011001010100;
  localparam logic [K*PW-1:0] GP_PART    = 30'b000000101001100100011001010100;
  localparam logic [K*PW-1:0] GP_ROW2_0  = 30'b010010101001100000001001010100;

  // clock / reset
  logic clk;
  logic i_rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic            i_cfg_we;
  logic [2:0]      i_cfg_addr;
  logic [PW-1:0]   i_cfg_data;
  logic            i_cfg_clr;
  logic            i_valid;
  logic [K-1:0]    i_info;
  logic            o_ready;
  logic            o_enc_en;
  logic [K-1:0]    o_info_bits;
  logic [K*PW-1:0] o_generator_p;
  logic [N-1:0]    i_codeword;
  logic            o_valid;
  logic [N-1:0]    o_codeword;
  logic            i_ready;
  logic            o_cfg_ok;
  logic            o_sys_err;
  logic [1:0]      dbg_state;
  logic            corrupt;

  int total;
  int bad;

  logic [PW-1:0] rows [K];

  ldpc_encode_ctrl #(.N(N), .K(K), .ENC_LAT(1)) dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_addr    (i_cfg_addr),
    .i_cfg_data    (i_cfg_data),
    .i_cfg_clr     (i_cfg_clr),
    .i_valid       (i_valid),
    .i_info        (i_info),
    .o_ready       (o_ready),
    .o_enc_en      (o_enc_en),
    .o_info_bits   (o_info_bits),
    .o_generator_p (o_generator_p),
    .i_codeword    (i_codeword),
    .o_valid       (o_valid),
    .o_codeword    (o_codeword),
    .i_ready       (i_ready),
    .o_cfg_ok      (o_cfg_ok),
    .o_sys_err     (o_sys_err),
    .dbg_state     (dbg_state)
  );

  // encoder model: {info, info*P}, optionally with bit N-1 flipped
  function automatic logic [N-1:0] enc_model(input logic [K-1:0] info,
                                             input logic [K*PW-1:0] gp);
    logic [PW-1:0] p;
    p = '0;
    for (int r = 0; r < K; r++) begin
      if (info[r]) p = p ^ gp[r*PW +: PW];
    end
    return {info, p};
  endfunction

  assign i_codeword = enc_model(o_info_bits, o_generator_p) ^
                      (corrupt ? 11'h400 : 11'h000);

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [PW-1:0] data);
    i_cfg_we   = 1'b1;
    i_cfg_addr = addr;
    i_cfg_data = data;
    tick();
    i_cfg_we   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rows[0] = 5'b10100; rows[1] = 5'b10010; rows[2] = 5'b10001;
    rows[3] = 5'b01100; rows[4] = 5'b01010; rows[5] = 5'b01001;
    i_rst_n = 1'b0; i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_data = '0;
    i_cfg_clr = 1'b0; i_valid = 1'b0; i_info = '0; i_ready = 1'b0;
    corrupt = 1'b0;

    // reset values
    #2;
    check("rst_ready",  32'(o_ready), 32'd0);
    check("rst_enc_en", 32'(o_enc_en), 32'd0);
    check("rst_valid",  32'(o_valid), 32'd0);
    check("rst_cfg_ok", 32'(o_cfg_ok), 32'd0);
    check("rst_sys_err", 32'(o_sys_err), 32'd0);
    check("rst_info",   32'(o_info_bits), 32'd0);
    check("rst_cw",     32'(o_codeword), 32'd0);
    check("rst_gp",     32'(o_generator_p), 32'd0);
    check("rst_state",  32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #3 i_rst_n = 1'b1;
    tick();

    // partial config: rows 0..4
    for (int r = 0; r < 5; r++) cfg_write(3'(r), rows[r]);
    check("part_cfg_ok", 32'(o_cfg_ok), 32'd0);
    check("part_ready",  32'(o_ready), 32'd0);
    check("part_gp",     32'(o_generator_p), 32'(GP_PART));
    // out-of-range address leaves mask and rows alone
    cfg_write(3'd6, 5'b11111);
    check("oor_cfg_ok", 32'(o_cfg_ok), 32'd0);
    check("oor_gp",     32'(o_generator_p), 32'(GP_PART));
    // valid while not configured is ignored
    i_valid = 1'b1; i_info = 6'b101010;
    tick(); tick();
    check("part_enc_en", 32'(o_enc_en), 32'd0);
    check("part_state",  32'(dbg_state), 32'd0);
    check("part_info",   32'(o_info_bits), 32'd0);
    i_valid = 1'b0;

    // last row completes config
    cfg_write(3'd5, rows[5]);
    check("cfg_gp",     32'(o_generator_p), 32'(GP_FULL));
    check("cfg_ok",     32'(o_cfg_ok), 32'd1);
    check("cfg_ready",  32'(o_ready), 32'd1);
    check("cfg_state",  32'(dbg_state), 32'd1);

    // encode 111111
    i_valid = 1'b1; i_info = 6'b111111;
    tick();
    i_valid = 1'b0;
    check("e1_enc_en", 32'(o_enc_en), 32'd1);
    check("e1_ready",  32'(o_ready), 32'd0);
    check("e1_info",   32'(o_info_bits), 32'h3f);
    check("e1_state",  32'(dbg_state), 32'd2);
    tick();
    check("e1_enc_off", 32'(o_enc_en), 32'd0);
    check("e1_valid",   32'(o_valid), 32'd1);
    check("e1_cw",      32'(o_codeword), 32'(11'b11111111000));
    check("e1_sys_err", 32'(o_sys_err), 32'd0);
    check("e1_hold",    32'(dbg_state), 32'd3);

    // back-pressure for 5 cycles, upstream activity ignored
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1; i_info = 6'(i * 7 + 1);
      tick();
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_cw",    32'(o_codeword), 32'(11'b11111111000));
      check("bp_ready", 32'(o_ready), 32'd0);
      check("bp_info",  32'(o_info_bits), 32'h3f);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("rel_state", 32'(dbg_state), 32'd1);
    check("rel_valid", 32'(o_valid), 32'd0);
    check("rel_ready", 32'(o_ready), 32'd1);

    // IDLE row rewrite, then restore
    cfg_write(3'd2, 5'b00000);
    check("rw_state", 32'(dbg_state), 32'd1);
    check("rw_gp",    32'(o_generator_p), 32'(GP_ROW2_0));
    cfg_write(3'd2, rows[2]);
    check("rw_restore", 32'(o_generator_p), 32'(GP_FULL));

    // corrupted encoder output, writes in ENC/HOLD ignored
    corrupt = 1'b1;
    i_valid = 1'b1; i_info = 6'b000001;
    tick();
    i_valid = 1'b0;
    i_cfg_we = 1'b1; i_cfg_addr = 3'd0; i_cfg_data = 5'b11111;
    tick();
    i_cfg_we = 1'b0;
    check("enc_wr_gp", 32'(o_generator_p), 32'(GP_FULL));
    check("err_cw",    32'(o_codeword), 32'(11'b10000110100));
    check("err_set",   32'(o_sys_err), 32'd1);
    cfg_write(3'd1, 5'b00000);
    check("hold_wr_gp", 32'(o_generator_p), 32'(GP_FULL));
    check("hold_wr_cfg_ok", 32'(o_cfg_ok), 32'd1);
    corrupt = 1'b0;
    i_ready = 1'b1;
    tick();
    check("err_idle", 32'(dbg_state), 32'd1);

    // clean word with i_ready high: one-cycle o_valid, sticky error
    i_valid = 1'b1; i_info = 6'b101010;
    tick();
    i_valid = 1'b0;
    check("tp_enc_en", 32'(o_enc_en), 32'd1);
    tick();
    check("tp_valid",  32'(o_valid), 32'd1);
    check("tp_cw",     32'(o_codeword), 32'(11'b10101010111));
    check("err_stick", 32'(o_sys_err), 32'd1);
    tick();
    check("tp_valid_off", 32'(o_valid), 32'd0);
    check("tp_ready",     32'(o_ready), 32'd1);
    i_ready = 1'b0;

    // clear in ENC with a simultaneous write: clear wins
    i_valid = 1'b1; i_info = 6'b000001;
    tick();
    i_valid = 1'b0;
    i_cfg_clr = 1'b1; i_cfg_we = 1'b1; i_cfg_addr = 3'd0; i_cfg_data = 5'b11111;
    tick();
    i_cfg_clr = 1'b0; i_cfg_we = 1'b0;
    check("clr_enc_en", 32'(o_enc_en), 32'd0);
    check("clr_valid",  32'(o_valid), 32'd0);
    check("clr_cfg_ok", 32'(o_cfg_ok), 32'd0);
    check("clr_ready",  32'(o_ready), 32'd0);
    check("clr_state",  32'(dbg_state), 32'd0);
    check("clr_sys_err", 32'(o_sys_err), 32'd1);
    check("clr_gp",     32'(o_generator_p), 32'(GP_FULL));
    tick();
    check("clr_drop", 32'(o_valid), 32'd0);
    for (int r = 1; r < K; r++) cfg_write(3'(r), rows[r]);
    check("clr_mask_cfg_ok", 32'(o_cfg_ok), 32'd0);
    check("clr_mask_ready",  32'(o_ready), 32'd0);
    cfg_write(3'd0, rows[0]);
    check("recfg_ok",    32'(o_cfg_ok), 32'd1);
    check("recfg_ready", 32'(o_ready), 32'd1);

    // async reset while in HOLD
    i_valid = 1'b1; i_info = 6'b111111;
    tick();
    i_valid = 1'b0;
    tick();
    check("ar_pre_valid", 32'(o_valid), 32'd1);
    #3 i_rst_n = 1'b0;
    #1;
    check("ar_valid",   32'(o_valid), 32'd0);
    check("ar_ready",   32'(o_ready), 32'd0);
    check("ar_enc_en",  32'(o_enc_en), 32'd0);
    check("ar_cfg_ok",  32'(o_cfg_ok), 32'd0);
    check("ar_sys_err", 32'(o_sys_err), 32'd0);
    check("ar_info",    32'(o_info_bits), 32'd0);
    check("ar_cw",      32'(o_codeword), 32'd0);
    check("ar_gp",      32'(o_generator_p), 32'd0);
    check("ar_state",   32'(dbg_state), 32'd0);
    #10 i_rst_n = 1'b1;
    tick();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
